// File: rtl/iter_step_sequencer_pkg.sv
// Shared definitions for the iterative-datapath step sequencer:
// state encodings and default iteration geometry.
package iter_step_sequencer_pkg;

  localparam int unsigned DEF_N_STEPS = 14;
  localparam int unsigned DEF_CW      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/iter_step_sequencer_step_counter.sv
// Mod-N step counter with synchronous clear and enable.
// The terminal flag is decoded from the registered count.
module step_counter #(
  parameter int unsigned N  = 14,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          term_c
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign term_c = (count_q == CW'(N - 1));
  assign count  = count_q;

  // Wrap at N, never at 2^CW.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = term_c ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/iter_step_sequencer.sv
// Control FSM sequencing a multi-cycle iterative datapath for exactly
// N_STEPS steps per operation, with start/abort/done handshake.
module iter_step_sequencer
  import iter_step_sequencer_pkg::*;
#(
  parameter int unsigned N_STEPS = DEF_N_STEPS,
  parameter int unsigned CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic          ld_en,
  output logic          step_en,
  output logic [CW-1:0] step_idx,
  output logic          last_step,
  output logic          done
);

  state_e        state_q;
  state_e        state_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt;
  logic          cnt_term;

  step_counter #(
    .N  (N_STEPS),
    .CW (CW)
  ) u_step_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (cnt),
    .term_c (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore outputs from registered state and count only.
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    ld_en     = 1'b0;
    step_en   = 1'b0;
    step_idx  = '0;
    last_step = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start && !abort) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        ld_en   = 1'b1;
        busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        step_en   = 1'b1;
        busy      = 1'b1;
        step_idx  = cnt;
        last_step = cnt_term;
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_term) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/iter_step_sequencer.md
Name: iter_step_sequencer

Overview:
Control FSM that sequences a multi-cycle iterative datapath, such as a shift-add multiplier or serial divider, for exactly N_STEPS iterations per operation.
- Accepts a start request and issues a one-cycle operand load.
- Drives one datapath step per cycle while an internal mod-N_STEPS step counter runs.
- Pulses done after the terminal step.
- Sits between the top-level control unit (start/abort/done handshake) and the datapath (load/step enables, step index).

Parameters:
N_STEPS, 14, number of datapath steps per operation; legal range 2..2^CW.
CW, 4, step-index width; 2^CW >= N_STEPS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
abort  input  1  cancel the in-flight operation; sampled in LOAD and RUN
ready  output  1  high in IDLE; a new start will be accepted
busy  output  1  high in LOAD and RUN
ld_en  output  1  datapath operand load strobe; high for one cycle in LOAD
step_en  output  1  datapath step enable; high every RUN cycle
step_idx  output  CW  current step number 0..N_STEPS-1, valid while step_en=1; 0 otherwise
last_step  output  1  high with step_en when step_idx == N_STEPS-1
done  output  1  one-cycle completion pulse in DONE

Behaviour:
- Reset and clock:
  - Single clock. Reset is synchronous and active-high.
  - rst sampled high at a clock edge gives: state=IDLE, counter=0, ready=1, all other outputs 0.
  - rst overrides start and abort.
  - rst mid-operation drops to IDLE on that edge. No done is issued.
- Output decoding:
  - All outputs are Moore-decoded from the registered state and the registered counter.
  - No combinational path from any input to any output.
- States (4, binary encoded):
  - IDLE: ready=1. start=1 and abort=0 -> LOAD. Otherwise stay in IDLE.
  - LOAD: ld_en=1, busy=1, counter cleared to 0. abort=1 -> IDLE. Otherwise -> RUN.
  - RUN: step_en=1, busy=1, step_idx=counter.
    - counter < N_STEPS-1: counter increments and state stays RUN.
    - counter == N_STEPS-1: last_step=1, counter wraps to 0, next state DONE.
    - abort=1 on any RUN cycle, including the last: -> IDLE, counter=0, no done.
  - DONE: done=1 for exactly one cycle, then unconditionally -> IDLE. start and abort are ignored in DONE.
- Latency, with start accepted at edge k:
  - ld_en is high in cycle k+1.
  - step_en is high in cycles k+2 .. k+N_STEPS+1.
  - done is high in cycle k+N_STEPS+2.
  - ready returns in cycle k+N_STEPS+3.
  - Total occupancy is N_STEPS+2 cycles.
- Back-to-back operation: start held high continuously is accepted in the first IDLE cycle. This gives one operation every N_STEPS+3 cycles.
- Ignored inputs:
  - start outside IDLE is ignored. It is not queued.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: abort wins and the FSM stays in IDLE.
- Counter arithmetic:
  - Unsigned, CW bits, wraps at N_STEPS and never at 2^CW.
  - The counter never holds a value >= N_STEPS.
- Illegal or unused state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11
  - default N_STEPS=14 and CW=4, shared with the datapath and other controllers
- One natural sub-module: step_counter.
  - Parameterised mod-N counter with synchronous active-high rst, clr and en inputs.
  - Outputs count[CW-1:0] and a combinational terminal flag (count == N-1).
  - The FSM drives clr in LOAD and en in RUN.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles, then 0 with start=0 -> ready=1; busy, ld_en, step_en, done all 0; step_idx=0 held for 10 cycles.
2. Nominal run (N_STEPS=14): start pulsed 1 cycle at edge k -> ld_en at k+1; step_en at k+2..k+15 with step_idx 0..13; last_step only at k+15; done at k+16; ready at k+17.
3. Back-to-back: start held high for 40 cycles -> ld_en at k+1, k+18, k+35; exactly 14 step_en cycles per operation; done at k+16 and k+33.
4. Abort mid-run: abort=1 when step_idx=5 -> next cycle IDLE, ready=1, no done, step_idx=0; a following start gives a full 14-step run starting from step_idx=0.
5. Priority and ignored inputs: start and abort both 1 in IDLE -> remains IDLE. start re-pulsed during RUN -> no effect on the sequence. rst=1 at step_idx=9 -> IDLE next cycle, done never asserted.
6. Parameter sweep: N_STEPS=2 with CW=1, and N_STEPS=16 with CW=4 -> step_en high for exactly N_STEPS cycles; step_idx wraps correctly; done at k+N_STEPS+2.
